// File: rtl/core_fetch_s.sv
// rtl/core_fetch_s.sv - fetch stage: PC owner, L1I requester, instruction buffer to decode
module core_fetch_s #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_enb,
  input  logic        fetch_redirect_val,
  input  logic [31:0] fetch_redirect_pc,
  output logic        fetch_l1i_req_val,
  output logic [31:0] fetch_l1i_req_addr,
  input  logic        fetch_l1i_ack_in,
  input  logic [31:0] fetch_l1i_rdata_in,
  output logic        fetch_val_out,
  output logic [31:0] fetch_inst_out,
  output logic [31:0] fetch_pc_out,
  output logic [31:0] fetch_pc_4_out
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // FETCH: normal sequential fetch. DROP: the outstanding request belongs to a
  // squashed path; its data is thrown away and fetch resumes at target.
  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_DROP  = 1'b1;

  logic [0:0]       state;
  logic [31:0]      pc;
  logic [31:0]      target;

  logic [31:0]      inst_mem [FIFO_DEPTH];
  logic [31:0]      pc_mem   [FIFO_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             fifo_empty;
  logic             fifo_full;
  logic             xfer;
  logic             push;
  logic             pop;
  logic             flush;
  logic [31:0]      redir_target;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == CNT_W'(FIFO_DEPTH));
  assign redir_target = fetch_redirect_pc & 32'hFFFF_FFFC;

  // A request is only issued when there is room for its data, so a pending
  // request never meets a full buffer; in DROP the request must be finished.
  assign fetch_l1i_req_val  = !rst && (((state == ST_FETCH) && !fifo_full) || (state == ST_DROP));
  assign fetch_l1i_req_addr = pc;

  assign xfer  = fetch_l1i_req_val && fetch_l1i_ack_in;
  assign flush = fetch_redirect_val;
  assign push  = (state == ST_FETCH) && xfer && !fetch_redirect_val;
  assign pop   = fetch_enb && !fifo_empty && !fetch_redirect_val;

  // PC / redirect-target / state sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      target <= 32'h0;
      state  <= ST_FETCH;
    end else begin
      case (state)
        ST_FETCH: begin
          if (fetch_redirect_val) begin
            if (fetch_l1i_req_val && !fetch_l1i_ack_in) begin
              // request in flight: keep its address stable, remember where to go
              target <= redir_target;
              state  <= ST_DROP;
            end else begin
              pc <= redir_target;
            end
          end else if (xfer) begin
            pc <= pc + 32'd4;
          end
        end
        ST_DROP: begin
          if (fetch_l1i_ack_in) begin
            pc    <= fetch_redirect_val ? redir_target : target;
            state <= ST_FETCH;
          end else if (fetch_redirect_val) begin
            target <= redir_target;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Buffer occupancy and pointers; a redirect empties the buffer outright
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Buffer payload; contents are only visible through a valid head
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[tail] <= fetch_l1i_rdata_in;
      pc_mem[tail]   <= pc;
    end
  end

  // Head presentation to decode, forced to zero when empty
  always_comb begin
    fetch_val_out  = !fifo_empty;
    fetch_inst_out = 32'h0;
    fetch_pc_out   = 32'h0;
    fetch_pc_4_out = 32'h0;
    if (!fifo_empty) begin
      fetch_inst_out = inst_mem[head];
      fetch_pc_out   = pc_mem[head];
      fetch_pc_4_out = pc_mem[head] + 32'd4;
    end
  end

endmodule

// File: tb/tb_core_fetch_s.sv
// tb/tb_core_fetch_s.sv - randomized self-checking bench for core_fetch_s
module tb_core_fetch_s;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_enb;
  logic        fetch_redirect_val;
  logic [31:0] fetch_redirect_pc;
  logic        fetch_l1i_req_val;
  logic [31:0] fetch_l1i_req_addr;
  logic        fetch_l1i_ack_in;
  logic [31:0] fetch_l1i_rdata_in;
  logic        fetch_val_out;
  logic [31:0] fetch_inst_out;
  logic [31:0] fetch_pc_out;
  logic [31:0] fetch_pc_4_out;

  core_fetch_s #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst                (rst),
    .fetch_enb          (fetch_enb),
    .fetch_redirect_val (fetch_redirect_val),
    .fetch_redirect_pc  (fetch_redirect_pc),
    .fetch_l1i_req_val  (fetch_l1i_req_val),
    .fetch_l1i_req_addr (fetch_l1i_req_addr),
    .fetch_l1i_ack_in   (fetch_l1i_ack_in),
    .fetch_l1i_rdata_in (fetch_l1i_rdata_in),
    .fetch_val_out      (fetch_val_out),
    .fetch_inst_out     (fetch_inst_out),
    .fetch_pc_out       (fetch_pc_out),
    .fetch_pc_4_out     (fetch_pc_4_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  logic [31:0] m_target;
  bit          m_wrong_path;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit exp_req(input bit r);
    return !r && (m_wrong_path || (q.size() < DEPTH));
  endfunction

  task automatic check_model();
    bit e = (q.size() == 0);
    check("req_val", 32'(fetch_l1i_req_val), 32'(exp_req(rst)));
    check("req_addr", fetch_l1i_req_addr, m_pc);
    check("val", 32'(fetch_val_out), 32'(!e));
    check("inst", fetch_inst_out, e ? 32'h0 : q[0].inst);
    check("pc", fetch_pc_out, e ? 32'h0 : q[0].pc);
    check("pc_4", fetch_pc_4_out, e ? 32'h0 : q[0].pc + 32'd4);
  endtask

  // One clock: drive inputs, advance the reference at the edge, compare at negedge.
  task automatic cycle(input bit r, input bit en, input bit rv, input logic [31:0] rp,
                       input bit a, input logic [31:0] rd);
    bit a_eff = a && exp_req(r);
    bit accept;
    logic [31:0] tgt = {rp[31:2], 2'b00};
    rst = r; fetch_enb = en; fetch_redirect_val = rv; fetch_redirect_pc = rp;
    fetch_l1i_ack_in = a_eff; fetch_l1i_rdata_in = rd;
    @(posedge clk);
    if (r) begin
      q.delete(); m_pc = 32'h0; m_target = 32'h0; m_wrong_path = 0;
    end else if (m_wrong_path) begin
      q.delete();
      if (a_eff) begin
        m_pc = rv ? tgt : m_target;
        m_wrong_path = 0;
      end else if (rv) begin
        m_target = tgt;
      end
    end else if (rv) begin
      q.delete();
      if (exp_req(0) && !a_eff) begin
        m_wrong_path = 1;
        m_target = tgt;
      end else begin
        m_pc = tgt;
      end
    end else begin
      accept = a_eff;
      if (en && q.size() > 0) void'(q.pop_front());
      if (accept) begin
        q.push_back('{inst: rd, pc: m_pc});
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clk);
    check_model();
  endtask

  initial begin
    rst = 1'b1; fetch_enb = 0; fetch_redirect_val = 0; fetch_redirect_pc = 0;
    fetch_l1i_ack_in = 0; fetch_l1i_rdata_in = 0;
    m_pc = 0; m_target = 0; m_wrong_path = 0;
    @(negedge clk);

    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    check("rst_req_val", 32'(fetch_l1i_req_val), 32'h0);
    check("rst_val", 32'(fetch_val_out), 32'h0);
    check("rst_addr", fetch_l1i_req_addr, 32'h0);

    cycle(0, 1, 0, 0, 0, 0);
    check("first_req", 32'(fetch_l1i_req_val), 32'h1);
    check("first_addr", fetch_l1i_req_addr, 32'h0);
    cycle(0, 1, 0, 0, 1, 32'hA000_0000);
    check("first_pc", fetch_pc_out, 32'h0);
    check("first_pc_4", fetch_pc_4_out, 32'h4);
    check("first_inst", fetch_inst_out, 32'hA000_0000);
    for (int i = 1; i < 6; i++) cycle(0, 1, 0, 0, 1, 32'hA000_0000 + 32'(i));

    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 32'hB000_0000 + 32'(i));
    check("full_req_low", 32'(fetch_l1i_req_val), 32'h0);
    check("full_val", 32'(fetch_val_out), 32'h1);
    cycle(0, 1, 0, 0, 1, 0);
    check("pop_req_high", 32'(fetch_l1i_req_val), 32'h1);

    cycle(0, 0, 1, 32'h10, 1, 32'hDEAD_0001);
    check("redir_flush", 32'(fetch_val_out), 32'h0);
    check("redir_addr", fetch_l1i_req_addr, 32'h10);
    cycle(0, 0, 1, 32'h103, 0, 0);
    check("drop_addr_held", fetch_l1i_req_addr, 32'h10);
    check("drop_req", 32'(fetch_l1i_req_val), 32'h1);
    cycle(0, 0, 0, 0, 1, 32'hDEAD_0002);
    check("drop_resume", fetch_l1i_req_addr, 32'h100);
    check("drop_no_data", 32'(fetch_val_out), 32'h0);

    cycle(0, 0, 1, 32'h40, 1, 32'hDEAD_0003);
    check("redir_ack_addr", fetch_l1i_req_addr, 32'h40);
    check("redir_ack_empty", 32'(fetch_val_out), 32'h0);

    cycle(0, 0, 1, 32'h80, 0, 0);
    cycle(0, 0, 1, 32'hC0, 0, 0);
    cycle(0, 0, 0, 0, 1, 32'hDEAD_0004);
    check("latest_redir", fetch_l1i_req_addr, 32'hC0);
    check("latest_empty", 32'(fetch_val_out), 32'h0);

    cycle(0, 0, 1, 32'hFFFF_FFFC, 1, 0);
    cycle(0, 0, 0, 0, 1, 32'h1111_1111);
    check("wrap_pc", fetch_pc_out, 32'hFFFF_FFFC);
    check("wrap_pc_4", fetch_pc_4_out, 32'h0);
    cycle(0, 1, 0, 0, 1, 32'h2222_2222);
    check("wrap_next_pc", fetch_pc_out, 32'h0);
    check("wrap_next_inst", fetch_inst_out, 32'h2222_2222);

    for (int i = 0; i < 3000; i++) begin
      bit          r  = ($urandom_range(0, 199) == 0);
      bit          en = ($urandom_range(0, 3) != 0);
      bit          rv = ($urandom_range(0, 7) == 0);
      logic [31:0] rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                    : $urandom;
      bit          a  = ($urandom_range(0, 2) != 0);
      cycle(r, en, rv, rp, a, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
